pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, single domain; all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: stallreq_if  in  1  fetch bus wait.
REQ-004 SHALL have ports: stallreq_id  in  1  load-use hazard.
REQ-005 SHALL have ports: stallreq_ex  in  1  multi-cycle EX operation busy.
REQ-006 SHALL have ports: stallreq_mem  in  1  data bus wait.
REQ-007 SHALL have ports: excp_valid  in  1  exception reported by MEM stage.
REQ-008 SHALL have ports: mret_valid  in  1  mret retiring in MEM stage.
REQ-009 SHALL have ports: mtvec, mepc  in  32 each  trap vector; return address.
REQ-010 SHALL have ports: stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage.
REQ-011 SHALL have ports: flush  out  1  clear all pipeline registers to bubbles.
REQ-012 SHALL have ports: new_pc  out  32  redirect target, valid while flush=1.
REQ-013 SHALL have ports: wdt_err  out  1  sticky stall-timeout flag (see Configuration).

Function
REQ-014 stall SHALL be combinational from requests, highest priority first: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-015 WB (stall[5]) SHALL never be held; a held MEM stage with WB free SHALL feed WB a bubble.
REQ-016 SHALL implement FSM states IDLE, PEND, FLUSH; state, flush and new_pc SHALL be registered.
REQ-017 IDLE: excp_valid or mret_valid with stallreq_mem=0 -> FLUSH next cycle (1-cycle latency).
REQ-018 IDLE: excp_valid or mret_valid with stallreq_mem=1 -> PEND; target latched at request cycle.
REQ-019 PEND: wait until stallreq_mem=0, then -> FLUSH; further exception/mret inputs ignored in PEND.
REQ-020 FLUSH: flush=1 for exactly one cycle, stall forced to 6'b000000, then -> IDLE.
REQ-021 FLUSH: excp_valid/mret_valid ignored (they originate from flushed instructions).
REQ-022 new_pc SHALL be mtvec for an exception, mepc for mret, sampled at the accepting cycle; holds last value when flush=0.
REQ-023 excp_valid and mret_valid in the same cycle: exception wins, new_pc=mtvec.
REQ-024 In PEND, stall SHALL follow REQ-014 (stallreq_mem holds PC..MEM).

Reset
REQ-025 On rst=0, asynchronously: state=IDLE, flush=0, new_pc=32'h0, wdt_err=0, watchdog counter=0.
REQ-026 Reset asserted in PEND or FLUSH SHALL discard the pending redirect; no flush after release.
REQ-027 stall SHALL reflect only the request inputs during reset.

Configuration
REQ-028 Macro PIPE_CTRL_WDT_EN SHALL compile in a 10-bit stall watchdog.
REQ-029 With PIPE_CTRL_WDT_EN defined:
- counter increments each cycle stall!=0
- counter clears on any cycle stall==0
- counter saturates at 1023
- wdt_err set when it reaches 1023; wdt_err stays set until reset.
REQ-030 Without PIPE_CTRL_WDT_EN: counter absent, wdt_err tied to 0.

Verification
REQ-031 stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111; add stallreq_mem=1 -> 6'b011111; all requests low -> 6'b000000.
REQ-032 mtvec=32'h0000_0100, excp_valid pulse in cycle N, no mem stall -> flush=1 and new_pc=32'h100 in cycle N+1 only, stall=0 that cycle.
REQ-033 mepc=32'h8000_0040, mret_valid with stallreq_mem=1 for 3 cycles -> PEND, flush=0 throughout; flush=1 with new_pc=32'h8000_0040 the cycle after stallreq_mem falls.
REQ-034 excp_valid and mret_valid in the same cycle -> new_pc=mtvec; excp_valid in the FLUSH cycle -> no second flush.
REQ-035 rst pulsed low while in PEND -> no flush after release, all outputs at reset values.
REQ-036 With PIPE_CTRL_WDT_EN, stallreq_if held 1023 cycles -> wdt_err=1 and stays 1 after release; without the macro -> wdt_err=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/redirect controller.
// Prioritises stage stall requests into a per-stage hold vector, and turns
// exceptions/mret retiring in MEM into a one-cycle flush with a redirect PC,
// deferring the redirect while the data bus is still busy.
// Optional build macro PIPE_CTRL_WDT_EN adds a 10-bit stall watchdog that
// raises a sticky wdt_err after 1023 consecutive stalled cycles.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        mret_valid,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdt_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_flush;
  logic [31:0] r_newPc;
  logic [31:0] r_target;
  logic [31:0] w_reqTarget;
  logic [31:0] w_pcSrc;
  logic        w_req;
  logic        w_loadPc;
  logic        w_latchTarget;
  logic [5:0]  w_stallReq;

  // Priority-encode stall requests; WB (bit 5) is never held so a held MEM feeds WB a bubble
  always_comb begin
    w_stallReq = 6'b000000;
    if (stallreq_mem)     w_stallReq = 6'b011111;
    else if (stallreq_ex) w_stallReq = 6'b001111;
    else if (stallreq_id) w_stallReq = 6'b000111;
    else if (stallreq_if) w_stallReq = 6'b000011;
  end

  // The flush cycle overrides every hold so the bubbles propagate everywhere
  assign stall = (r_state == FLUSH) ? 6'b000000 : w_stallReq;

  // Exception takes precedence over mret when both retire together
  assign w_req       = excp_valid | mret_valid;
  assign w_reqTarget = excp_valid ? mtvec : mepc;

  // Redirect FSM next-state: accept in IDLE, wait out the data bus in PEND, flush once
  always_comb begin
    w_nextState   = r_state;
    w_loadPc      = 1'b0;
    w_latchTarget = 1'b0;
    w_pcSrc       = r_target;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (stallreq_mem) begin
            w_nextState   = PEND;
            w_latchTarget = 1'b1;
          end else begin
            w_nextState = FLUSH;
            w_loadPc    = 1'b1;
            w_pcSrc     = w_reqTarget;
          end
        end
      end
      PEND: begin
        if (!stallreq_mem) begin
          w_nextState = FLUSH;
          w_loadPc    = 1'b1;
          w_pcSrc     = r_target;
        end
      end
      FLUSH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, flush pulse, redirect target and the deferred target held while pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_flush  <= 1'b0;
      r_newPc  <= 32'h0;
      r_target <= 32'h0;
    end else begin
      r_state <= w_nextState;
      r_flush <= (w_nextState == FLUSH);
      if (w_loadPc)      r_newPc  <= w_pcSrc;
      if (w_latchTarget) r_target <= w_reqTarget;
    end
  end

  assign flush  = r_flush;
  assign new_pc = r_newPc;

`ifdef PIPE_CTRL_WDT_EN
  logic [9:0] r_wdtCnt;
  logic [9:0] w_wdtNext;
  logic       r_wdtErr;

  // Count consecutive stalled cycles, saturating at the top of the range
  always_comb begin
    w_wdtNext = 10'd0;
    if (stall != 6'b000000) begin
      w_wdtNext = (r_wdtCnt == 10'd1023) ? r_wdtCnt : r_wdtCnt + 10'd1;
    end
  end

  // Watchdog counter and sticky error, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdtCnt <= 10'd0;
      r_wdtErr <= 1'b0;
    end else begin
      r_wdtCnt <= w_wdtNext;
      if (w_wdtNext == 10'd1023) r_wdtErr <= 1'b1;
    end
  end

  assign wdt_err = r_wdtErr;
`else
  assign wdt_err = 1'b0;
`endif

endmodule
